// File: rtl/multiplexer_3ch_pkg.sv
// Shared constants for the registered 3-to-1 word multiplexer:
// select encodings and the default datapath word width.
package multiplexer_3ch_pkg;

    localparam int DEFAULT_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_C    = 2'b10,
        SEL_NONE = 2'b11
    } mux_sel_e;

endpackage

// File: rtl/multiplexer_3ch.sv
// Registered 3-to-1 word multiplexer: one combinational select stage
// feeding a word_size-bit register with synchronous active-low clear.
module multiplexer_3ch
    import multiplexer_3ch_pkg::*;
#(
    parameter int word_size = DEFAULT_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [word_size-1:0] mux_out,
    input  logic [word_size-1:0] data_a,
    input  logic [word_size-1:0] data_b,
    input  logic [word_size-1:0] data_c,
    input  logic [1:0]           sel
);

    logic [word_size-1:0] w_next;
    logic [word_size-1:0] r_mux_out;

    // Conditional chain rather than a case so an unknown sel propagates
    // as X in simulation instead of silently falling into the zero arm.
    always_comb begin
        w_next = '0;
        w_next = (sel == SEL_A) ? data_a :
                 (sel == SEL_B) ? data_b :
                 (sel == SEL_C) ? data_c :
                 {word_size{1'b0}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mux_out <= '0;
        end else begin
            r_mux_out <= w_next;
        end
    end

    assign mux_out = r_mux_out;

endmodule

// File: tb/tb_multiplexer_3ch.sv
// Directed and random checks of the registered 3-to-1 multiplexer using
// an expected-value queue filled at drive time and drained after each edge.
module tb_multiplexer_3ch;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] mux_out;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] data_c;
    logic [1:0]   sel;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;

    multiplexer_3ch #(.word_size(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mux_out (mux_out),
        .data_a  (data_a),
        .data_b  (data_b),
        .data_c  (data_c),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic r, input logic [1:0] s,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
        if (!r) return '0;
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return '0;
        endcase
    endfunction

    // Pop one expectation and compare it against the current output.
    task automatic check(input string tag);
        logic [W-1:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, scoreboard queue empty", tag, mux_out);
        end else begin
            exp = exp_q.pop_front();
            assert (mux_out === exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, mux_out, exp);
            end
        end
    endtask

    // Drive one vector away from the active edge, then check after the edge.
    task automatic step(input logic r, input logic [1:0] s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input string tag);
        @(negedge clk);
        rst_n  = r;
        sel    = s;
        data_a = a;
        data_b = b;
        data_c = c;
        exp_q.push_back(model(r, s, a, b, c));
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        logic [2:0] sel3;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        sel    = 2'd0;
        data_a = 8'hFC;
        data_b = 8'hFD;
        data_c = 8'hFE;

        step(1'b0, 2'd0, 8'hFC, 8'hFD, 8'hFE, "reset_edge1");
        step(1'b0, 2'd0, 8'hFC, 8'hFD, 8'hFE, "reset_edge2");

        step(1'b1, 2'd0, 8'hFC, 8'hFD, 8'hFE, "sel_a");
        step(1'b1, 2'd1, 8'hFC, 8'hFD, 8'hFE, "sel_b");
        step(1'b1, 2'd2, 8'hFC, 8'hFD, 8'hFE, "sel_c");

        step(1'b1, 2'd3, 8'hFC, 8'hFD, 8'hFE, "sel_none");
        step(1'b1, 2'd1, 8'hFC, 8'hFD, 8'hFE, "sel_back_b");

        sel3 = 3'b100;
        step(1'b1, sel3[1:0], 8'hFC, 8'hFD, 8'hFE, "sel_trunc");

        // Hold: data_b changes between edges, output must not follow yet.
        step(1'b1, 2'd1, 8'hFC, 8'hFD, 8'hFE, "hold_pre");
        @(negedge clk);
        data_b = 8'h5A;
        exp_q.push_back(8'hFD);
        #1;
        check("hold_between_edges");
        exp_q.push_back(model(rst_n, sel, data_a, data_b, data_c));
        @(posedge clk);
        #1;
        check("hold_after_edge");

        step(1'b1, 2'd2, 8'hFC, 8'hFD, 8'hFE, "mid_pre");
        step(1'b0, 2'd2, 8'hFC, 8'hFD, 8'hFE, "mid_reset");
        step(1'b1, 2'd2, 8'hFC, 8'hFD, 8'hFE, "mid_release");

        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 9) != 0),
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)),
                 "random");
        end

        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL queue_drain: observed %0d left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
